cii_cursor_writer: RTL and testbench

//  Write-side controller for the character table RAM (70x30 text screen).
//  - Accepts ASCII codes from the keyboard/decoder over a valid/ready handshake.
//  - Tracks the text cursor and drives the RAM write port (we, char_x_we, char_y_we, ascii_we).
//  - Blanks the whole screen after reset and on request. The display read path is independent.

---
 rtl/cii_cursor_writer_if.sv | 25 ++
 rtl/cii_cursor_writer.sv | 171 +++++++++++++++++
 tb/tb_cii_cursor_writer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cii_cursor_writer_if.sv
// Keyboard-side handshake, clear request, RAM write port and cursor/busy status
// for the character table writer.
interface cii_cursor_writer_if;
  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;
  logic       clear;
  logic       we;
  logic [6:0] char_x_we;
  logic [4:0] char_y_we;
  logic [7:0] ascii_we;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  modport master (
    output in_valid, in_ascii, clear,
    input  in_ready, we, char_x_we, char_y_we, ascii_we, cur_x, cur_y, busy
  );

  modport slave (
    input  in_valid, in_ascii, clear,
    output in_ready, we, char_x_we, char_y_we, ascii_we, cur_x, cur_y, busy
  );
endinterface

// File: rtl/cii_cursor_writer.sv
// Write-side controller for the 70x30 character table: blanks the screen, then
// places typed characters at the cursor. Optional tab stops via CII_TAB_EN.
module cii_cursor_writer #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input logic             clk,
  input logic             rst,
  cii_cursor_writer_if.slave bus
);

  typedef enum logic [0:0] {CLEAR, IDLE} state_e;

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
  localparam logic [4:0] Y_END = 5'(ROWS);

  state_e     state_q, state_d;
  logic [6:0] sx_q, sx_d;
  logic [4:0] sy_q, sy_d;
  logic [6:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic       we_q, we_d;
  logic [6:0] wx_q, wx_d;
  logic [4:0] wy_q, wy_d;
  logic [7:0] wa_q, wa_d;
  logic       busy_q, busy_d;
  logic       in_ready;
  logic       hs;
  logic [7:0] code;
`ifdef CII_TAB_EN
  logic [7:0] tab_x;
`endif

  function automatic logic [4:0] next_row(input logic [4:0] y);
    return (y == Y_MAX) ? 5'd0 : y + 5'd1;
  endfunction

  assign in_ready = (state_q == IDLE) && !bus.clear;
  assign hs       = bus.in_valid && in_ready;
  assign code     = bus.in_ascii;

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    we_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wa_d    = wa_q;
    busy_d  = busy_q;
`ifdef CII_TAB_EN
    tab_x   = {1'b0, cx_q | 7'h07} + 8'd1;
`endif
    case (state_q)
      CLEAR: begin
        if (bus.clear) begin
          // Restart: (0,0) goes out now, the sweep resumes from (1,0).
          we_d = 1'b1;
          wx_d = 7'd0;
          wy_d = 5'd0;
          wa_d = BLANK;
          sx_d = 7'd1;
          sy_d = 5'd0;
        end else if (sy_q == Y_END) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cx_d    = 7'd0;
          cy_d    = 5'd0;
        end else begin
          we_d = 1'b1;
          wx_d = sx_q;
          wy_d = sy_q;
          wa_d = BLANK;
          if (sx_q == X_MAX) begin
            sx_d = 7'd0;
            sy_d = sy_q + 5'd1;
          end else begin
            sx_d = sx_q + 7'd1;
          end
        end
      end
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          sx_d    = 7'd0;
          sy_d    = 5'd0;
        end else if (hs) begin
          if (code >= 8'h20 && code <= 8'h7E) begin
            we_d = 1'b1;
            wx_d = cx_q;
            wy_d = cy_q;
            wa_d = code;
            if (cx_q == X_MAX) begin
              cx_d = 7'd0;
              cy_d = next_row(cy_q);
            end else begin
              cx_d = cx_q + 7'd1;
            end
          end else if (code == 8'h0A || code == 8'h0D) begin
            cx_d = 7'd0;
            cy_d = next_row(cy_q);
          end else if (code == 8'h08) begin
            if (cx_q != 7'd0) begin
              cx_d = cx_q - 7'd1;
            end else if (cy_q != 5'd0) begin
              cx_d = X_MAX;
              cy_d = cy_q - 5'd1;
            end
            // Blank lands on the post-move cell, so compute it from the _d values.
            we_d = 1'b1;
            wx_d = cx_d;
            wy_d = cy_d;
            wa_d = BLANK;
          end
`ifdef CII_TAB_EN
          else if (code == 8'h09) begin
            if (tab_x >= 8'(COLS)) begin
              cx_d = 7'd0;
              cy_d = next_row(cy_q);
            end else begin
              cx_d = tab_x[6:0];
            end
          end
`endif
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      sx_q    <= 7'd0;
      sy_q    <= 5'd0;
      cx_q    <= 7'd0;
      cy_q    <= 5'd0;
      we_q    <= 1'b0;
      wx_q    <= 7'd0;
      wy_q    <= 5'd0;
      wa_q    <= 8'd0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wa_q    <= wa_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.we        = we_q;
  assign bus.char_x_we = wx_q;
  assign bus.char_y_we = wy_q;
  assign bus.ascii_we  = wa_q;
  assign bus.cur_x     = cx_q;
  assign bus.cur_y     = cy_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cii_cursor_writer.sv
// Randomized self-checking bench for cii_cursor_writer against a linear-position
// cursor model. Define CII_TAB_EN for both RTL and bench to cover tab stops.
module tb_cii_cursor_writer;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mx = 0;
  int   my = 0;

  cii_cursor_writer_if w();
  cii_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk(clk), .rst(rst), .bus(w)
  );

  always #10 clk = ~clk;

  // Reference: cursor as a linear cell index p = y*COLS + x on a torus of CELLS.
  task automatic ref_step(input logic [7:0] c, output bit ew, output int ex,
                          output int ey, output logic [7:0] ea);
    int p;
    p = my * COLS + mx;
    ew = 0; ex = 0; ey = 0; ea = 8'h00;
    if (c >= 8'h20 && c <= 8'h7E) begin
      ew = 1; ex = mx; ey = my; ea = c;
      p = (p + 1) % CELLS;
    end else if (c == 8'h0A || c == 8'h0D) begin
      p = ((my + 1) % ROWS) * COLS;
    end else if (c == 8'h08) begin
      if (p > 0) p = p - 1;
      ew = 1; ex = p % COLS; ey = p / COLS; ea = 8'h20;
    end
`ifdef CII_TAB_EN
    else if (c == 8'h09) begin
      int nx;
      nx = (mx / 8 + 1) * 8;
      p = (nx >= COLS) ? ((my + 1) % ROWS) * COLS : my * COLS + nx;
    end
`endif
    mx = p % COLS;
    my = p / COLS;
  endtask

  task automatic send(input logic [7:0] c);
    w.in_valid = 1'b1;
    w.in_ascii = c;
    @(posedge clk); #1;
    w.in_valid = 1'b0;
  endtask

  task automatic goto_xy(input int tx, input int ty);
    bit ew; int ex, ey; logic [7:0] ea;
    ref_step(8'h0A, ew, ex, ey, ea); send(8'h0A);
    while (my != ty) begin ref_step(8'h0A, ew, ex, ey, ea); send(8'h0A); end
    while (mx != tx) begin ref_step(8'h2E, ew, ex, ey, ea); send(8'h2E); end
  endtask

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 8'($urandom_range(32, 126));
      6:       return ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
      7:       return 8'h08;
      8:       return 8'h09;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_reset();
    int idx;
    w.in_valid = 1'b0; w.in_ascii = 8'h00; w.clear = 1'b0;
    #5 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (w.we !== 1'b0 || w.busy !== 1'b1 || w.cur_x !== 7'd0 || w.cur_y !== 5'd0 ||
        w.in_ready !== 1'b0 || w.ascii_we !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: we=%b busy=%b cur=(%0d,%0d) rdy=%b a=%h, want 0 1 (0,0) 0 00",
               w.we, w.busy, w.cur_x, w.cur_y, w.in_ready, w.ascii_we);
    end
    @(negedge clk) rst = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < CELLS + 50; cyc++) begin
      @(posedge clk); #1;
      if (!w.busy) break;
      n_chk++;
      if (w.we !== 1'b1 || w.char_x_we !== 7'(idx % COLS) || w.char_y_we !== 5'(idx / COLS) ||
          w.ascii_we !== 8'h20) begin
        n_fail++;
        $display("FAIL reset_sweep[%0d]: we=%b (%0d,%0d) a=%h, want 1 (%0d,%0d) 20",
                 idx, w.we, w.char_x_we, w.char_y_we, w.ascii_we, idx % COLS, idx / COLS);
      end
      idx++;
    end
    n_chk++;
    if (idx !== CELLS || w.busy !== 1'b0 || w.we !== 1'b0 || w.in_ready !== 1'b1 ||
        w.cur_x !== 7'd0 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_done: pulses=%0d busy=%b we=%b rdy=%b cur=(%0d,%0d), want %0d 0 0 1 (0,0)",
               idx, w.busy, w.we, w.in_ready, w.cur_x, w.cur_y, CELLS);
    end
    mx = 0; my = 0;
  endtask

  task automatic test_printable();
    bit ew; int ex, ey; logic [7:0] ea;
    n_chk++;
    if (w.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL print_ready: in_ready=%b, want 1", w.in_ready);
    end
    ref_step(8'h41, ew, ex, ey, ea);
    send(8'h41);
    n_chk++;
    if (w.we !== 1'b1 || w.char_x_we !== 7'd0 || w.char_y_we !== 5'd0 || w.ascii_we !== 8'h41 ||
        w.cur_x !== 7'd1 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL print_A: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want 1 (0,0) 41 (1,0)",
               w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y);
    end
    @(posedge clk); #1;
    n_chk++;
    if (w.we !== 1'b0) begin
      n_fail++; $display("FAIL print_pulse: we=%b one cycle later, want 0", w.we);
    end
  endtask

  task automatic test_wrap();
    bit ew; int ex, ey; logic [7:0] ea;
    goto_xy(0, 0);
    for (int i = 0; i < COLS; i++) begin ref_step(8'h42, ew, ex, ey, ea); send(8'h42); end
    n_chk++;
    if (w.we !== 1'b1 || w.char_x_we !== 7'd69 || w.char_y_we !== 5'd0 || w.ascii_we !== 8'h42 ||
        w.cur_x !== 7'd0 || w.cur_y !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_row: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want 1 (69,0) 42 (0,1)",
               w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y);
    end
    goto_xy(69, 29);
    ref_step(8'h43, ew, ex, ey, ea);
    send(8'h43);
    n_chk++;
    if (w.we !== 1'b1 || w.char_x_we !== 7'd69 || w.char_y_we !== 5'd29 || w.ascii_we !== 8'h43 ||
        w.cur_x !== 7'd0 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_screen: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want 1 (69,29) 43 (0,0)",
               w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y);
    end
  endtask

  task automatic test_backspace();
    bit ew; int ex, ey; logic [7:0] ea;
    goto_xy(0, 1);
    ref_step(8'h08, ew, ex, ey, ea);
    send(8'h08);
    n_chk++;
    if (w.we !== 1'b1 || w.char_x_we !== 7'd69 || w.char_y_we !== 5'd0 || w.ascii_we !== 8'h20 ||
        w.cur_x !== 7'd69 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_row: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want 1 (69,0) 20 (69,0)",
               w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y);
    end
    goto_xy(0, 0);
    ref_step(8'h08, ew, ex, ey, ea);
    send(8'h08);
    n_chk++;
    if (w.we !== 1'b1 || w.char_x_we !== 7'd0 || w.char_y_we !== 5'd0 || w.ascii_we !== 8'h20 ||
        w.cur_x !== 7'd0 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_origin: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want 1 (0,0) 20 (0,0)",
               w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y);
    end
  endtask

  task automatic test_newline_tab();
    bit ew; int ex, ey; logic [7:0] ea;
    goto_xy(5, 3);
    ref_step(8'h0D, ew, ex, ey, ea);
    send(8'h0D);
    n_chk++;
    if (w.we !== 1'b0 || w.cur_x !== 7'd0 || w.cur_y !== 5'd4) begin
      n_fail++;
      $display("FAIL cr: we=%b cur=(%0d,%0d), want 0 (0,4)", w.we, w.cur_x, w.cur_y);
    end
    goto_xy(3, 0);
    ref_step(8'h09, ew, ex, ey, ea);
    send(8'h09);
    n_chk++;
`ifdef CII_TAB_EN
    if (w.we !== 1'b0 || w.cur_x !== 7'd8 || w.cur_y !== 5'd0) begin
      n_fail++; $display("FAIL tab_3: we=%b cur=(%0d,%0d), want 0 (8,0)", w.we, w.cur_x, w.cur_y);
    end
`else
    if (w.we !== 1'b0 || w.cur_x !== 7'd3 || w.cur_y !== 5'd0) begin
      n_fail++; $display("FAIL tab_3: we=%b cur=(%0d,%0d), want 0 (3,0)", w.we, w.cur_x, w.cur_y);
    end
`endif
    goto_xy(66, 0);
    ref_step(8'h09, ew, ex, ey, ea);
    send(8'h09);
    n_chk++;
    if (w.we !== 1'b0 || w.cur_x !== 7'(mx) || w.cur_y !== 5'(my)) begin
      n_fail++;
      $display("FAIL tab_66: we=%b cur=(%0d,%0d), want 0 (%0d,%0d)", w.we, w.cur_x, w.cur_y, mx, my);
    end
  endtask

  task automatic test_back_to_back();
    bit ew; int ex, ey; logic [7:0] ea; logic [7:0] c;
    c = rand_code();
    ref_step(c, ew, ex, ey, ea);
    w.in_valid = 1'b1; w.in_ascii = c;
    for (int i = 0; i < 400; i++) begin
      #1;
      n_chk++;
      if (w.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, w.in_ready);
      end
      @(posedge clk); #1;
      n_chk++;
      if (w.we !== ew || (ew && (w.char_x_we !== 7'(ex) || w.char_y_we !== 5'(ey) ||
          w.ascii_we !== ea)) || w.cur_x !== 7'(mx) || w.cur_y !== 5'(my)) begin
        n_fail++;
        $display("FAIL b2b[%0d] code=%h: we=%b (%0d,%0d) a=%h cur=(%0d,%0d), want %b (%0d,%0d) %h (%0d,%0d)",
                 i, c, w.we, w.char_x_we, w.char_y_we, w.ascii_we, w.cur_x, w.cur_y,
                 ew, ex, ey, ea, mx, my);
      end
      c = rand_code();
      ref_step(c, ew, ex, ey, ea);
      w.in_ascii = c;
    end
    w.in_valid = 1'b0;
  endtask

  task automatic test_clear();
    int  idx;
    bit  restarted;
    logic [6:0] hold_x;
    hold_x = w.cur_x;
    w.in_valid = 1'b1; w.in_ascii = 8'h5A; w.clear = 1'b1;
    #1;
    n_chk++;
    if (w.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready: in_ready=%b with clear, want 0", w.in_ready);
    end
    @(posedge clk); #1;
    w.clear = 1'b0; w.in_valid = 1'b0;
    n_chk++;
    if (w.we !== 1'b0 || w.busy !== 1'b1 || w.cur_x !== hold_x) begin
      n_fail++;
      $display("FAIL clear_enter: we=%b busy=%b cur_x=%0d, want 0 1 %0d", w.we, w.busy, w.cur_x, hold_x);
    end
    idx = 0; restarted = 0;
    for (int cyc = 0; cyc < 2 * CELLS + 100; cyc++) begin
      @(posedge clk); #1;
      w.clear = 1'b0;
      if (!w.busy) break;
      n_chk++;
      if (w.we !== 1'b1 || w.char_x_we !== 7'(idx % COLS) || w.char_y_we !== 5'(idx / COLS) ||
          w.ascii_we !== 8'h20) begin
        n_fail++;
        $display("FAIL clear_sweep[%0d] restarted=%0d: we=%b (%0d,%0d) a=%h, want 1 (%0d,%0d) 20",
                 idx, restarted, w.we, w.char_x_we, w.char_y_we, w.ascii_we, idx % COLS, idx / COLS);
      end
      idx++;
      if (!restarted && idx == 500) begin
        w.clear = 1'b1; restarted = 1; idx = 0;
      end
    end
    n_chk++;
    if (idx !== CELLS || w.busy !== 1'b0 || w.we !== 1'b0 || w.in_ready !== 1'b1 ||
        w.cur_x !== 7'd0 || w.cur_y !== 5'd0) begin
      n_fail++;
      $display("FAIL clear_done: pulses=%0d busy=%b we=%b rdy=%b cur=(%0d,%0d), want %0d 0 0 1 (0,0)",
               idx, w.busy, w.we, w.in_ready, w.cur_x, w.cur_y, CELLS);
    end
    mx = 0; my = 0;
  endtask

  initial begin
    test_reset();
    test_printable();
    test_wrap();
    test_backspace();
    test_newline_tab();
    test_back_to_back();
    test_clear();
    test_printable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
